// File: rtl/xvec2_valu_seq_pkg.sv
// Shared definitions for the xvec2 vector ALU sequencer: vscale ALU opcodes,
// lane geometry defaults and the sequencer FSM state encoding.
package xvec2_valu_seq_pkg;

  localparam int XPR_LEN      = 32;
  localparam int SHAMT_WIDTH  = 5;
  localparam int VEC_SIZE     = 4;
  localparam int VEC_XPR_LEN  = VEC_SIZE * XPR_LEN;
  localparam int ALU_OP_WIDTH = 4;

  typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

  localparam alu_op_t ALU_OP_ADD  = 4'd0;
  localparam alu_op_t ALU_OP_SLL  = 4'd1;
  localparam alu_op_t ALU_OP_XOR  = 4'd4;
  localparam alu_op_t ALU_OP_SRL  = 4'd5;
  localparam alu_op_t ALU_OP_OR   = 4'd6;
  localparam alu_op_t ALU_OP_AND  = 4'd7;
  localparam alu_op_t ALU_OP_SEQ  = 4'd8;
  localparam alu_op_t ALU_OP_SNE  = 4'd9;
  localparam alu_op_t ALU_OP_SUB  = 4'd10;
  localparam alu_op_t ALU_OP_SRA  = 4'd11;
  localparam alu_op_t ALU_OP_SLT  = 4'd12;
  localparam alu_op_t ALU_OP_SGE  = 4'd13;
  localparam alu_op_t ALU_OP_SLTU = 4'd14;
  localparam alu_op_t ALU_OP_SGEU = 4'd15;

  typedef enum logic [1:0] {
    XVEC2_SEQ_IDLE = 2'd0,
    XVEC2_SEQ_EXEC = 2'd1,
    XVEC2_SEQ_DONE = 2'd2
  } state_t;

  // Compares and unassigned encodings have no lane datapath here.
  function automatic logic alu_op_illegal(input alu_op_t op);
    case (op)
      ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
      ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA: alu_op_illegal = 1'b0;
      default:                            alu_op_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/xvec2_valu_seq_if.sv
// Request/response bundle between the xvec2 issue stage (master) and the
// vector ALU sequencer (slave). req_mask exists only with XVEC2_VALU_SEQ_LANE_MASK_EN.
interface xvec2_valu_seq_if #(
  parameter int VEC_SIZE = xvec2_valu_seq_pkg::VEC_SIZE,
  parameter int XPR_LEN  = xvec2_valu_seq_pkg::XPR_LEN
) ();
  import xvec2_valu_seq_pkg::*;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // The sender holds valid and payload until that edge; ready may depend on
  // state only, never on valid. kill aborts an accepted op without a transfer.
  logic                        req_valid;
  logic                        req_ready;
  alu_op_t                     req_op;
  logic [VEC_SIZE*XPR_LEN-1:0] req_in1;
  logic [VEC_SIZE*XPR_LEN-1:0] req_in2;
  logic                        kill;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [VEC_SIZE*XPR_LEN-1:0] resp_out;
  logic                        resp_illegal;
  logic                        busy;
`ifdef XVEC2_VALU_SEQ_LANE_MASK_EN
  logic [VEC_SIZE-1:0]         req_mask;
`endif

  modport master (
    output req_valid, req_op, req_in1, req_in2, kill, resp_ready,
`ifdef XVEC2_VALU_SEQ_LANE_MASK_EN
    output req_mask,
`endif
    input  req_ready, resp_valid, resp_out, resp_illegal, busy
  );

  modport slave (
    input  req_valid, req_op, req_in1, req_in2, kill, resp_ready,
`ifdef XVEC2_VALU_SEQ_LANE_MASK_EN
    input  req_mask,
`endif
    output req_ready, resp_valid, resp_out, resp_illegal, busy
  );

endinterface

// File: rtl/xvec2_lane_alu.sv
// Combinational single-lane ALU for the xvec2 sequencer; unsupported ops
// give out=0 with illegal=1.
module xvec2_lane_alu #(
  parameter int XPR_LEN = xvec2_valu_seq_pkg::XPR_LEN
) (
  input  xvec2_valu_seq_pkg::alu_op_t op,
  input  logic [XPR_LEN-1:0]          a,
  input  logic [XPR_LEN-1:0]          b,
  input  logic [$clog2(XPR_LEN)-1:0]  shamt,
  output logic [XPR_LEN-1:0]          out,
  output logic                        illegal
);
  import xvec2_valu_seq_pkg::*;

  always_comb begin
    out     = '0;
    illegal = 1'b0;
    case (op)
      ALU_OP_ADD: out = a + b;
      ALU_OP_SUB: out = a - b;
      ALU_OP_AND: out = a & b;
      ALU_OP_OR:  out = a | b;
      ALU_OP_XOR: out = a ^ b;
      ALU_OP_SLL: out = a << shamt;
      ALU_OP_SRL: out = a >> shamt;
      ALU_OP_SRA: out = $unsigned($signed(a) >>> shamt);
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/xvec2_valu_seq.sv
// Multi-cycle xvec2 vector ALU sequencer: runs one vector op through
// LANES_PER_BEAT lane ALUs per cycle. Optional lane masking: XVEC2_VALU_SEQ_LANE_MASK_EN.
module xvec2_valu_seq #(
  parameter int VEC_SIZE       = xvec2_valu_seq_pkg::VEC_SIZE,
  parameter int XPR_LEN        = xvec2_valu_seq_pkg::XPR_LEN,
  parameter int LANES_PER_BEAT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  xvec2_valu_seq_if.slave            bus,
  output xvec2_valu_seq_pkg::state_t fsm_state
);
  import xvec2_valu_seq_pkg::*;

  localparam int NBEATS = VEC_SIZE / LANES_PER_BEAT;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int SHW    = $clog2(XPR_LEN);
  localparam int W      = VEC_SIZE * XPR_LEN;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

  if (LANES_PER_BEAT < 1 || (VEC_SIZE % LANES_PER_BEAT) != 0) begin : g_bad_cfg
    $error("xvec2_valu_seq: LANES_PER_BEAT must divide VEC_SIZE");
  end

  state_t              state, state_next;
  logic [BEAT_W-1:0]   beat, first_beat, next_beat;
  logic                first_any, next_any;
  alu_op_t             op_q;
  logic [W-1:0]        in1_q, in2_q, res_q, res_init;
  logic                ill_q;
  logic [LANES_PER_BEAT*XPR_LEN-1:0] lane_out;
  logic [LANES_PER_BEAT-1:0]         lane_ill, lane_en;

  for (genvar l = 0; l < LANES_PER_BEAT; l++) begin : g_lane
    xvec2_lane_alu #(.XPR_LEN(XPR_LEN)) u_lane (
      .op      (op_q),
      .a       (in1_q[(int'(beat) * LANES_PER_BEAT + l) * XPR_LEN +: XPR_LEN]),
      .b       (in2_q[(int'(beat) * LANES_PER_BEAT + l) * XPR_LEN +: XPR_LEN]),
      .shamt   (in2_q[SHW-1:0]),
      .out     (lane_out[l * XPR_LEN +: XPR_LEN]),
      .illegal (lane_ill[l])
    );
  end

`ifdef XVEC2_VALU_SEQ_LANE_MASK_EN
  logic [VEC_SIZE-1:0] mask_q;
  logic [NBEATS-1:0]   act_req, act_q;

  // Masked lanes start out holding in1 and are never overwritten.
  assign res_init = bus.req_in1;

  always_comb begin
    act_req    = '0;
    act_q      = '0;
    first_beat = '0;
    first_any  = 1'b0;
    next_beat  = '0;
    next_any   = 1'b0;
    for (int b = 0; b < NBEATS; b++) begin
      act_req[b] = |bus.req_mask[b * LANES_PER_BEAT +: LANES_PER_BEAT];
      act_q[b]   = |mask_q[b * LANES_PER_BEAT +: LANES_PER_BEAT];
    end
    // Descending scan leaves the lowest qualifying beat selected.
    for (int b = NBEATS - 1; b >= 0; b--) begin
      if (act_req[b]) begin
        first_beat = BEAT_W'(b);
        first_any  = 1'b1;
      end
      if (act_q[b] && b > int'(beat)) begin
        next_beat = BEAT_W'(b);
        next_any  = 1'b1;
      end
    end
    for (int l = 0; l < LANES_PER_BEAT; l++) begin
      lane_en[l] = mask_q[int'(beat) * LANES_PER_BEAT + l];
    end
  end
`else
  assign res_init   = '0;
  assign first_beat = '0;
  assign first_any  = 1'b1;
  assign next_any   = (beat != LAST_BEAT);
  assign next_beat  = next_any ? BEAT_W'(beat + 1'b1) : '0;
  assign lane_en    = '1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      XVEC2_SEQ_IDLE: if (bus.req_valid) state_next = first_any ? XVEC2_SEQ_EXEC : XVEC2_SEQ_DONE;
      XVEC2_SEQ_EXEC: begin
        if (bus.kill)       state_next = XVEC2_SEQ_IDLE;
        else if (!next_any) state_next = XVEC2_SEQ_DONE;
      end
      XVEC2_SEQ_DONE: if (bus.kill || bus.resp_ready) state_next = XVEC2_SEQ_IDLE;
      default:        state_next = XVEC2_SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= XVEC2_SEQ_IDLE;
      beat  <= '0;
      op_q  <= '0;
      in1_q <= '0;
      in2_q <= '0;
      res_q <= '0;
      ill_q <= 1'b0;
`ifdef XVEC2_VALU_SEQ_LANE_MASK_EN
      mask_q <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
        XVEC2_SEQ_IDLE: if (bus.req_valid) begin
          op_q  <= bus.req_op;
          in1_q <= bus.req_in1;
          in2_q <= bus.req_in2;
          res_q <= res_init;
          ill_q <= alu_op_illegal(bus.req_op);
          beat  <= first_beat;
`ifdef XVEC2_VALU_SEQ_LANE_MASK_EN
          mask_q <= bus.req_mask;
`endif
        end
        XVEC2_SEQ_EXEC: begin
          if (bus.kill) begin
            beat <= '0;
          end else begin
            for (int l = 0; l < LANES_PER_BEAT; l++) begin
              if (lane_en[l])
                res_q[(int'(beat) * LANES_PER_BEAT + l) * XPR_LEN +: XPR_LEN] <= lane_out[l * XPR_LEN +: XPR_LEN];
            end
            ill_q <= ill_q | (|lane_ill);
            beat  <= next_beat;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready    = (state == XVEC2_SEQ_IDLE);
  assign bus.resp_valid   = (state == XVEC2_SEQ_DONE);
  assign bus.busy         = (state != XVEC2_SEQ_IDLE);
  assign bus.resp_out     = res_q;
  assign bus.resp_illegal = ill_q;
  assign fsm_state        = state;

endmodule

// File: tb/tb_xvec2_valu_seq.sv
// Self-checking bench for xvec2_valu_seq (default build): scoreboarded ops,
// latency, hold, kill and reset cases, plus a one-beat instance.
module tb_xvec2_valu_seq;
  import xvec2_valu_seq_pkg::*;

  localparam int W = VEC_XPR_LEN;
  localparam int L = XPR_LEN;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t fsm_state, fsm_state4;

  xvec2_valu_seq_if #(.VEC_SIZE(VEC_SIZE), .XPR_LEN(XPR_LEN)) bus  ();
  xvec2_valu_seq_if #(.VEC_SIZE(VEC_SIZE), .XPR_LEN(XPR_LEN)) bus4 ();

  xvec2_valu_seq #(.VEC_SIZE(VEC_SIZE), .XPR_LEN(XPR_LEN), .LANES_PER_BEAT(1)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .fsm_state(fsm_state)
  );

  xvec2_valu_seq #(.VEC_SIZE(VEC_SIZE), .XPR_LEN(XPR_LEN), .LANES_PER_BEAT(4)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave), .fsm_state(fsm_state4)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_ill_q[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic [L-1:0] l3, l2, l1, l0);
    return {l3, l2, l1, l0};
  endfunction

  // Reference lane model; result bit W carries the illegal flag.
  function automatic logic [W:0] model(input alu_op_t op, input logic [W-1:0] a, b);
    logic [W-1:0]   r;
    logic           ill;
    logic [L-1:0]   x, y;
    logic [2*L-1:0] ext;
    int             sh;
    r   = '0;
    ill = 1'b0;
    sh  = int'(b[SHAMT_WIDTH-1:0]);
    for (int i = 0; i < VEC_SIZE; i++) begin
      x   = a[i*L +: L];
      y   = b[i*L +: L];
      ext = {{L{x[L-1]}}, x} >> sh;
      case (op)
        ALU_OP_ADD: r[i*L +: L] = x + y;
        ALU_OP_SUB: r[i*L +: L] = x + ~y + 1;
        ALU_OP_AND: r[i*L +: L] = x & y;
        ALU_OP_OR:  r[i*L +: L] = x | y;
        ALU_OP_XOR: r[i*L +: L] = x ^ y;
        ALU_OP_SLL: r[i*L +: L] = x << sh;
        ALU_OP_SRL: r[i*L +: L] = x >> sh;
        ALU_OP_SRA: r[i*L +: L] = ext[L-1:0];
        default:    ill = 1'b1;
      endcase
    end
    if (ill) r = '0;
    return {ill, r};
  endfunction

  task automatic drive_idle();
    bus.req_valid  = 1'b0;
    bus.req_op     = ALU_OP_ADD;
    bus.req_in1    = '0;
    bus.req_in2    = '0;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;
    bus4.req_valid  = 1'b0;
    bus4.req_op     = ALU_OP_ADD;
    bus4.req_in1    = '0;
    bus4.req_in2    = '0;
    bus4.kill       = 1'b0;
    bus4.resp_ready = 1'b0;
  endtask

  // Drives one request; exp pushed at drive time, popped when resp_valid appears.
  task automatic run_op(input string tag, input alu_op_t op, input logic [W-1:0] a, b,
                        input logic [W-1:0] exp_out, input logic exp_ill,
                        input int hold, input logic kill_idle);
    int cnt;
    logic [W-1:0] got_exp;
    logic         got_ill;
    @(negedge clk);
    check({tag, "_ready"}, W'(bus.req_ready), W'(1));
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_in1   = a;
    bus.req_in2   = b;
    bus.kill      = kill_idle;
    exp_q.push_back(exp_out);
    exp_ill_q.push_back(exp_ill);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.kill      = 1'b0;
    bus.req_op    = ALU_OP_XOR;
    bus.req_in1   = ~a;
    bus.req_in2   = ~b;
    check({tag, "_busy"}, W'(bus.busy), W'(1));
    cnt = 0;
    while (!bus.resp_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_latency"}, W'(cnt), W'(4));
    got_exp = exp_q.pop_front();
    got_ill = exp_ill_q.pop_front();
    if (bus.resp_valid) begin
      for (int h = 0; h < hold; h++) begin
        check({tag, "_hold_valid"}, W'(bus.resp_valid), W'(1));
        check({tag, "_hold_out"}, bus.resp_out, got_exp);
        check({tag, "_hold_req_ready"}, W'(bus.req_ready), W'(0));
        @(posedge clk); #1;
      end
      check({tag, "_out"}, bus.resp_out, got_exp);
      check({tag, "_illegal"}, W'(bus.resp_illegal), W'(got_ill));
      @(negedge clk);
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      check({tag, "_after_valid"}, W'(bus.resp_valid), W'(0));
      check({tag, "_after_ready"}, W'(bus.req_ready), W'(1));
    end
  endtask

  // Accepts an ADD and leaves the sequencer in EXEC with beat 2 next.
  task automatic start_and_reach_beat2();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = ALU_OP_ADD;
    bus.req_in1   = pack(32'd1, 32'd2, 32'd3, 32'd4);
    bus.req_in2   = pack(32'd5, 32'd6, 32'd7, 32'd8);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_in_exec", W'(fsm_state), W'(XVEC2_SEQ_EXEC));
  endtask

  task automatic expect_quiet(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen = 1'b1;
    end
    check({tag, "_no_resp"}, W'(seen), W'(0));
  endtask

  logic [W-1:0] ra, rb, ones, zero;
  logic [W:0]   m;
  alu_op_t      legal_ops[8];
  int           cnt4;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    legal_ops = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR,
                  ALU_OP_XOR, ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA};
    ones = '1;
    zero = '0;
    drive_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_req_ready", W'(bus.req_ready), W'(1));
    check("rst_resp_valid", W'(bus.resp_valid), W'(0));
    check("rst_resp_out", bus.resp_out, zero);
    check("rst_resp_illegal", W'(bus.resp_illegal), W'(0));
    check("rst_busy", W'(bus.busy), W'(0));
    check("rst_state", W'(fsm_state), W'(XVEC2_SEQ_IDLE));

    // lanes listed msb-first: lane3..lane0
    run_op("add", ALU_OP_ADD, pack(32'd1, 32'd2, 32'd3, 32'd4), pack(32'd40, 32'd30, 32'd20, 32'd10),
           pack(32'd41, 32'd32, 32'd23, 32'd14), 1'b0, 0, 1'b0);
    run_op("sra", ALU_OP_SRA, pack(32'h12345678, 32'hFFFF0000, 32'h00000100, 32'h80000000),
           pack(32'd31, 32'd31, 32'd31, 32'd4),
           pack(32'h01234567, 32'hFFFFF000, 32'h00000010, 32'hF8000000), 1'b0, 0, 1'b0);
    run_op("sub_wrap", ALU_OP_SUB, zero, pack(32'd1, 32'd1, 32'd1, 32'd1), ones, 1'b0, 5, 1'b0);
    run_op("slt", ALU_OP_SLT, pack(32'd1, 32'd2, 32'd3, 32'd4), pack(32'd9, 32'd9, 32'd9, 32'd9),
           zero, 1'b1, 0, 1'b0);
    run_op("undef_op", 4'd2, ones, ones, zero, 1'b1, 0, 1'b0);
    run_op("kill_idle", ALU_OP_XOR, pack(32'hF0F0F0F0, 32'h0, 32'hFFFFFFFF, 32'h12345678),
           pack(32'h0F0F0F0F, 32'h1, 32'hFFFFFFFF, 32'h0),
           pack(32'hFFFFFFFF, 32'h1, 32'h0, 32'h12345678), 1'b0, 0, 1'b1);

    // kill mid-EXEC
    start_and_reach_beat2();
    @(negedge clk);
    bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    check("kill_state", W'(fsm_state), W'(XVEC2_SEQ_IDLE));
    check("kill_req_ready", W'(bus.req_ready), W'(1));
    check("kill_busy", W'(bus.busy), W'(0));
    expect_quiet("kill");
    run_op("add_after_kill", ALU_OP_ADD, pack(32'd7, 32'hFFFFFFFF, 32'd100, 32'd0),
           pack(32'd3, 32'd2, 32'd200, 32'd5), pack(32'd10, 32'd1, 32'd300, 32'd5), 1'b0, 0, 1'b0);

    // reset mid-EXEC
    start_and_reach_beat2();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_state", W'(fsm_state), W'(XVEC2_SEQ_IDLE));
    check("rst_mid_out", bus.resp_out, zero);
    check("rst_mid_req_ready", W'(bus.req_ready), W'(1));
    @(negedge clk);
    reset = 1'b0;
    expect_quiet("rst_mid");
    run_op("add_after_reset", ALU_OP_ADD, pack(32'd1, 32'd1, 32'd1, 32'd1),
           pack(32'd2, 32'd2, 32'd2, 32'd2), pack(32'd3, 32'd3, 32'd3, 32'd3), 1'b0, 0, 1'b0);

    // kill together with resp_ready in DONE discards the response
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = ALU_OP_OR;
    bus.req_in1   = ones;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("kdone_valid", W'(bus.resp_valid), W'(1));
    @(negedge clk);
    bus.kill       = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.kill       = 1'b0;
    bus.resp_ready = 1'b0;
    check("kdone_state", W'(fsm_state), W'(XVEC2_SEQ_IDLE));
    check("kdone_resp_valid", W'(bus.resp_valid), W'(0));

    // random legal ops
    for (int t = 0; t < 8; t++) begin
      alu_op_t op;
      op = legal_ops[$urandom_range(0, 7)];
      for (int i = 0; i < VEC_SIZE; i++) begin
        ra[i*L +: L] = $urandom;
        rb[i*L +: L] = $urandom;
      end
      m = model(op, ra, rb);
      run_op($sformatf("rand%0d_op%0d", t, op), op, ra, rb, m[W-1:0], m[W], 0, 1'b0);
    end

    // all lanes in one beat: one-cycle latency
    @(negedge clk);
    bus4.req_valid = 1'b1;
    bus4.req_in1   = pack(32'd4, 32'd3, 32'd2, 32'hFFFFFFFF);
    bus4.req_in2   = pack(32'd1, 32'd1, 32'd1, 32'd2);
    @(posedge clk); #1;
    bus4.req_valid = 1'b0;
    bus4.req_in1   = '0;
    cnt4 = 0;
    while (!bus4.resp_valid && cnt4 < 20) begin
      @(posedge clk); #1;
      cnt4++;
    end
    check("lpb4_latency", W'(cnt4), W'(1));
    check("lpb4_out", bus4.resp_out, pack(32'd5, 32'd4, 32'd3, 32'd1));
    @(negedge clk);
    bus4.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus4.resp_ready = 1'b0;
    check("lpb4_after_ready", W'(bus4.req_ready), W'(1));

    check("sb_empty", W'(exp_q.size()), W'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
